// File: rtl/mem_copy_master.sv
// Word-by-word block copier on the picorv32 native bus: read src, one idle cycle, write dst, one idle cycle.
// 6 cycles per word against a one-wait responder; holds each request until acknowledged or the watchdog expires.
module mem_copy_master #(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [LEN_W-1:0] words_done,
    output logic             mem_valid,
    output logic             mem_instr,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic [31:0]      mem_rdata
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD     = 3'd1;
    localparam logic [2:0] S_RD_GAP = 3'd2;
    localparam logic [2:0] S_WR     = 3'd3;
    localparam logic [2:0] S_WR_GAP = 3'd4;
    localparam logic [2:0] S_FIN    = 3'd5;

    localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [2:0]       state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [31:0]      hold_q, hold_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [LEN_W-1:0] wdone_q, wdone_d;
    logic             vld_q, vld_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic             wd_fire;

    // The request has been pending TIMEOUT cycles once this edge lands without ready.
    assign wd_fire = (TIMEOUT > 0) && vld_q && !mem_ready && (wdog_q == WD_LAST);

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        hold_d  = hold_q;
        wdog_d  = wdog_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = error_q;
        wdone_d = wdone_q;
        vld_d   = vld_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;

        if (vld_q && !mem_ready) begin
            wdog_d = wdog_q + WD_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d   = src_addr & 32'hFFFF_FFFC;
                    dst_d   = dst_addr & 32'hFFFF_FFFC;
                    len_d   = len_words;
                    error_d = 1'b0;
                    wdone_d = '0;
                    busy_d  = 1'b1;
                    if (len_words == '0) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_RD;
                        vld_d   = 1'b1;
                        addr_d  = src_addr & 32'hFFFF_FFFC;
                        wstrb_d = 4'b0000;
                        wdog_d  = '0;
                    end
                end
            end
            S_RD: begin
                if (mem_ready) begin
                    hold_d  = mem_rdata;
                    vld_d   = 1'b0;
                    src_d   = src_q + 32'd4;
                    state_d = S_RD_GAP;
                end else if (wd_fire) begin
                    vld_d   = 1'b0;
                    error_d = 1'b1;
                    state_d = S_FIN;
                end
            end
            // Responder's ready is registered and stale for one cycle after an ack.
            S_RD_GAP: begin
                state_d = S_WR;
                vld_d   = 1'b1;
                addr_d  = dst_q;
                wdata_d = hold_q;
                wstrb_d = 4'b1111;
                wdog_d  = '0;
            end
            S_WR: begin
                if (mem_ready) begin
                    vld_d   = 1'b0;
                    dst_d   = dst_q + 32'd4;
                    wdone_d = wdone_q + LEN_W'(1);
                    state_d = S_WR_GAP;
                end else if (wd_fire) begin
                    vld_d   = 1'b0;
                    error_d = 1'b1;
                    state_d = S_FIN;
                end
            end
            S_WR_GAP: begin
                if (wdone_q == len_q) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_RD;
                    vld_d   = 1'b1;
                    addr_d  = src_q;
                    wstrb_d = 4'b0000;
                    wdog_d  = '0;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                vld_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            hold_q  <= '0;
            wdog_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            wdone_q <= '0;
            vld_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            hold_q  <= hold_d;
            wdog_q  <= wdog_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            wdone_q <= wdone_d;
            vld_q   <= vld_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign words_done = wdone_q;
    assign mem_valid  = vld_q;
    assign mem_instr  = 1'b0;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_wstrb  = wstrb_q;
endmodule

// File: tb/tb_mem_copy_master.sv
// Directed bench: behavioural memory responder with configurable wait states plus a bus-protocol monitor.
module tb_mem_copy_master;
    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [31:0] src_addr, dst_addr;
    logic [15:0] len_words;
    logic        busy, done, error;
    logic [15:0] words_done;
    logic        mem_valid, mem_instr, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    mem_copy_master #(.LEN_W(16), .TIMEOUT(8)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
        .busy(busy), .done(done), .error(error), .words_done(words_done),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Responder: ready rises after wait_n+1 cycles of valid, held one cycle.
    logic [31:0] mem [64];
    int          wait_n    = 0;
    logic        never_rdy = 1'b0;
    int          wcnt;

    always @(posedge clk) begin
        if (!resetn) begin
            mem_ready <= 1'b0;
            wcnt      <= 0;
        end else begin
            mem_ready <= 1'b0;
            if (!mem_valid) begin
                wcnt <= 0;
            end else if (!mem_ready && !never_rdy) begin
                if (wcnt == wait_n) begin
                    mem_ready <= 1'b1;
                    wcnt      <= 0;
                    mem_rdata <= mem[mem_addr[7:2]];
                    if (mem_wstrb == 4'hF) mem[mem_addr[7:2]] = mem_wdata;
                end else begin
                    wcnt <= wcnt + 1;
                end
            end
        end
    end

    // Protocol monitor
    int          vld_cycles, acks, stab_viol, gap_viol, drop_viol, done_cnt, gap;
    logic        p_vld, p_ack, seen_ack;
    logic [31:0] p_addr, p_wdata;
    logic [3:0]  p_wstrb;
    logic [31:0] log_addr[$];
    logic [3:0]  log_wstrb[$];

    task automatic clr_mon();
        vld_cycles = 0; acks = 0; stab_viol = 0; gap_viol = 0; drop_viol = 0;
        done_cnt = 0; gap = 0; p_vld = 0; p_ack = 0; seen_ack = 0;
        log_addr.delete(); log_wstrb.delete();
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            if (mem_valid) vld_cycles++;
            if (mem_valid && p_vld && !p_ack &&
                (mem_addr !== p_addr || mem_wdata !== p_wdata || mem_wstrb !== p_wstrb)) stab_viol++;
            if (p_ack && mem_valid) gap_viol++;
            if (mem_valid && !p_vld && seen_ack && gap != 1) gap_viol++;
            if (!mem_valid && p_vld && !p_ack) drop_viol++;
            if (done) done_cnt++;
            if (mem_valid && mem_ready) begin
                acks++;
                seen_ack = 1'b1;
                log_addr.push_back(mem_addr);
                log_wstrb.push_back(mem_wstrb);
            end
            if (mem_valid) gap = 0; else gap++;
            p_vld = mem_valid; p_ack = mem_valid && mem_ready;
            p_addr = mem_addr; p_wdata = mem_wdata; p_wstrb = mem_wstrb;
        end
    end

    // Returns at the negedge after the start edge.
    task automatic go(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        @(negedge clk);
        clr_mon();
        src_addr = s; dst_addr = d; len_words = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    int          n;
    logic [31:0] exp_addr[4];
    logic [3:0]  exp_wstrb[4];

    initial begin
        resetn = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len_words = '0;
        clr_mon();
        for (int i = 0; i < 64; i++) mem[i] = (i < 8) ? 32'h1111_1111 * i : 32'h0;
        #1;
        chk("rst_valid", {31'b0, mem_valid}, 32'd0);
        chk("rst_busy",  {31'b0, busy}, 32'd0);
        chk("rst_done",  {31'b0, done}, 32'd0);
        chk("rst_error", {31'b0, error}, 32'd0);
        chk("rst_wdone", {16'b0, words_done}, 32'd0);
        chk("rst_addr",  mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_wstrb", {28'b0, mem_wstrb}, 32'd0);
        chk("rst_instr", {31'b0, mem_instr}, 32'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        // Basic 4-word copy, single-wait responder
        go(32'h0, 32'h40, 16'd4);
        chk("t1_first_valid", {31'b0, mem_valid}, 32'd1);
        chk("t1_busy", {31'b0, busy}, 32'd1);
        wait_done(n);
        chk("t1_latency", n, 32'd25);
        chk("t1_wdone", {16'b0, words_done}, 32'd4);
        chk("t1_error", {31'b0, error}, 32'd0);
        chk("t1_busy_end", {31'b0, busy}, 32'd0);
        for (int i = 0; i < 4; i++) chk($sformatf("t1_mem%0d", 16 + i), mem[16 + i], 32'h1111_1111 * i);
        repeat (2) @(negedge clk);
        chk("t1_done_cnt", done_cnt, 32'd1);
        chk("t1_acks", acks, 32'd8);
        chk("t1_gaps", gap_viol, 32'd0);

        // Zero-length copy
        go(32'h0, 32'h40, 16'd0);
        chk("t2_busy", {31'b0, busy}, 32'd1);
        wait_done(n);
        chk("t2_latency", n, 32'd1);
        chk("t2_busy_end", {31'b0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        chk("t2_no_valid", vld_cycles, 32'd0);
        chk("t2_done_cnt", done_cnt, 32'd1);

        // Three wait states per transaction
        wait_n = 3;
        go(32'h10, 32'h80, 16'd4);
        wait_done(n);
        chk("t3_latency", n, 32'd49);
        for (int i = 0; i < 4; i++) chk($sformatf("t3_mem%0d", 32 + i), mem[32 + i], 32'h1111_1111 * (4 + i));
        chk("t3_stable", stab_viol, 32'd0);
        chk("t3_gaps", gap_viol, 32'd0);
        chk("t3_drops", drop_viol, 32'd0);
        chk("t3_wdone", {16'b0, words_done}, 32'd4);
        wait_n = 0;

        // Watchdog abort, then error cleared by the next start
        never_rdy = 1'b1;
        go(32'h0, 32'h40, 16'd4);
        wait_done(n);
        chk("t4_latency", n, 32'd9);
        chk("t4_error", {31'b0, error}, 32'd1);
        chk("t4_vld_cycles", vld_cycles, 32'd8);
        chk("t4_drops", drop_viol, 32'd1);
        chk("t4_wdone", {16'b0, words_done}, 32'd0);
        never_rdy = 1'b0;
        @(negedge clk);
        chk("t4_error_held", {31'b0, error}, 32'd1);
        go(32'h1C, 32'hC0, 16'd1);
        chk("t4b_error_clr", {31'b0, error}, 32'd0);
        wait_done(n);
        chk("t4b_latency", n, 32'd7);
        chk("t4b_mem48", mem[48], 32'h7777_7777);
        chk("t4b_wdone", {16'b0, words_done}, 32'd1);

        // Reset during the write of the second word
        go(32'h4, 32'hA0, 16'd4);
        repeat (9) @(negedge clk);
        chk("t5_in_write", {27'b0, mem_valid, mem_wstrb}, 32'h1F);
        resetn = 1'b0;
        #1;
        chk("t5_valid_rst", {31'b0, mem_valid}, 32'd0);
        chk("t5_busy_rst", {31'b0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        clr_mon();
        repeat (20) @(negedge clk);
        chk("t5_no_valid", vld_cycles, 32'd0);
        chk("t5_wdone", {16'b0, words_done}, 32'd0);
        chk("t5_mem40", mem[40], 32'h1111_1111);
        chk("t5_mem41", mem[41], 32'h0);

        // Unaligned source ignored bits, destination wraps past 2^32
        go(32'h3, 32'hFFFF_FFFC, 16'd2);
        wait_done(n);
        chk("t6_latency", n, 32'd13);
        chk("t6_acks", log_addr.size(), 32'd4);
        exp_addr  = '{32'h0, 32'hFFFF_FFFC, 32'h4, 32'h0};
        exp_wstrb = '{4'h0, 4'hF, 4'h0, 4'hF};
        for (int i = 0; i < 4; i++) begin
            if (i < log_addr.size()) begin
                chk($sformatf("t6_addr%0d", i), log_addr[i], exp_addr[i]);
                chk($sformatf("t6_wstrb%0d", i), {28'b0, log_wstrb[i]}, {28'b0, exp_wstrb[i]});
            end
        end
        chk("t6_mem63", mem[63], 32'h0);
        chk("t6_mem0", mem[0], 32'h1111_1111);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_copy_master.md
Name: mem_copy_master

Overview:
- Bus initiator on the picorv32 native memory interface (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata).
- Copies a block of 32-bit words from a source address to a destination address by issuing alternating read and write transactions to a memory responder (e.g. the on-chip BRAM responder).
- Used for block moves and for exercising the BRAM responder independently of the CPU.
- Configured by a simple start/busy/done control port.

Parameters:
- LEN_W, 16, width of the word-count input and the progress counter.
- TIMEOUT, 255, max cycles mem_valid may stay high without mem_ready; 0 disables the watchdog.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a copy; sampled only in IDLE.
- src_addr  input  32  source byte address; bits [1:0] ignored (treated as 0).
- dst_addr  input  32  destination byte address; bits [1:0] ignored.
- len_words  input  LEN_W  number of words to copy.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse at completion or abort.
- error  output  1  set on watchdog abort; held until the next accepted start.
- words_done  output  LEN_W  count of completed word copies (write acknowledged).
- mem_valid  output  1  transaction request.
- mem_instr  output  1  tied 0.
- mem_ready  input  1  responder acknowledge.
- mem_addr  output  32  word-aligned transaction address.
- mem_wdata  output  32  write data.
- mem_wstrb  output  4  4'b1111 on writes, 4'b0000 on reads.
- mem_rdata  input  32  read data, valid when mem_ready is sampled high on a read.

Behaviour:
- Reset (async, any state): state=IDLE; mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0; busy=0, done=0, error=0, words_done=0. All outputs registered. A reset mid-transfer abandons it with no further bus activity.
- States: IDLE, RD, RD_GAP, WR, WR_GAP, FIN.
- IDLE:
  - start=1 latches src/dst (low 2 bits zeroed) and len, clears error and words_done, sets busy=1.
  - len=0 -> FIN; else -> RD.
  - start is ignored in every other state.
- RD:
  - mem_valid=1, mem_addr=src, mem_wstrb=0.
  - On an edge with mem_valid=1 and mem_ready=1: capture mem_rdata into the holding register, drop mem_valid, src+=4 (mod 2^32) -> RD_GAP.
- RD_GAP: exactly one cycle with mem_valid=0 -> WR. mem_ready is ignored whenever mem_valid=0, because the responder registers mem_ready and holds it stale one cycle.
- WR:
  - mem_valid=1, mem_addr=dst, mem_wdata=holding register, mem_wstrb=4'b1111.
  - On acknowledge: drop mem_valid, dst+=4, words_done+=1 -> WR_GAP.
- WR_GAP: one idle cycle; if words_done==len -> FIN, else -> RD.
- FIN: done=1 for one cycle, busy=0 on the same edge -> IDLE.
- Bus stability: mem_addr, mem_wdata and mem_wstrb are constant while mem_valid=1. mem_valid never drops before an acknowledge, except on watchdog abort.
- Watchdog: a counter clears when mem_valid rises and increments each cycle with mem_valid=1 and mem_ready=0. When the counter reaches TIMEOUT (TIMEOUT>0): drop mem_valid, set error=1 -> FIN. words_done keeps the count of completed words.
- Timing with the BRAM responder (ready one cycle after valid):
  - 6 cycles per word.
  - First mem_valid is high in the cycle after the start edge.
  - done pulses 6*len+1 cycles after the start edge (len>0), or 1 cycle after it for len=0.
- Overlapping src/dst ranges copy in ascending order with no special handling.

Test Plan:
- Reset, BRAM responder preloaded with words 0..7 = 0x11111111*i; start src=0x00, dst=0x40, len=4 -> words 16..19 = words 0..3; words_done=4; done pulses once, 25 cycles after start; error=0.
- len=0 start -> no mem_valid ever; done pulses the cycle after start; busy high for one cycle.
- Responder inserting 3 wait cycles per transaction; check on every cycle -> mem_addr/mem_wdata/mem_wstrb stable while valid; one idle cycle between transactions; copy correct.
- Responder never asserts ready, TIMEOUT=8 -> mem_valid drops after 8 cycles high; error=1; done pulse; words_done=0; next start clears error.
- Assert resetn low mid-write of word 2 of 4 -> mem_valid=0 and busy=0 immediately; no further transactions; words_done=0 after release.
- src=0x0000_0003, dst=0xFFFF_FFFC, len=2 -> reads at 0x0 and 0x4; writes at 0xFFFF_FFFC then 0x0000_0000 (wrap).
